// File: rtl/pistorm_pkg.sv
// Shared constants for the PiStorm posted-transaction queue: register map,
// queue entry layout and issue FSM encoding.
package pistorm_pkg;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_ADDR_LO = 2'd1;
  localparam logic [1:0] REG_ADDR_HI = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  // Control bits carried in an ADDR_HI write alongside the upper address byte.
  localparam int HI_BYTE_BIT = 8;
  localparam int HI_RW_BIT   = 9;

  // Entry layout, LSB first: lds_n, uds_n, rw, wdata, addr.
  localparam int ENTRY_LDS      = 0;
  localparam int ENTRY_UDS      = 1;
  localparam int ENTRY_RW       = 2;
  localparam int ENTRY_DATA_LSB = 3;

  function automatic int entry_addr_lsb(input int data_w);
    return ENTRY_DATA_LSB + data_w;
  endfunction

  function automatic int entry_width(input int addr_w, input int data_w);
    return addr_w + data_w + 3;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } issue_state_t;

endpackage

// File: rtl/pistorm_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; a push into a full FIFO is only
// accepted when a pop happens in the same cycle.
module pistorm_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers define which slots are meaningful.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/pistorm_txn_queue.sv
// Posted-transaction queue: assembles Pi register writes into 68K bus ops,
// buffers them, and issues them one at a time to the bus-cycle engine.
module pistorm_txn_queue
  import pistorm_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
) (
  input  logic              PI_CLK,
  input  logic              PI_RST,
  input  logic              reg_wr,
  input  logic [1:0]        reg_sel,
  input  logic [DATA_W-1:0] reg_wdata,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [ADDR_W-1:0] op_addr,
  output logic [DATA_W-1:0] op_wdata,
  output logic              op_rw,
  output logic              op_uds_n,
  output logic              op_lds_n,
  input  logic              op_done,
  input  logic [DATA_W-1:0] op_rdata,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              full,
  output logic              overflow
);

  localparam int EW   = entry_width(ADDR_W, DATA_W);
  localparam int ALSB = entry_addr_lsb(DATA_W);
  localparam int CW   = $clog2(DEPTH) + 1;

  issue_state_t      state_q, state_d;
  logic [DATA_W-1:0] stage_data_q, stage_data_d;
  logic [15:0]       stage_addr_q, stage_addr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              inflight_rd_q, inflight_rd_d;
  logic              overflow_q, overflow_d;
  logic              busy_q, busy_d;
  logic              full_q, full_d;

  logic              push_req;
  logic              push_ok;
  logic              pop;
  logic [EW-1:0]     push_entry;
  logic [EW-1:0]     fifo_head;
  logic [CW-1:0]     fifo_count;
  logic [CW-1:0]     count_d;
  logic              fifo_full;
  logic              fifo_empty;

  pistorm_sync_fifo #(
    .WIDTH(EW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (PI_CLK),
    .rst    (PI_RST),
    .push   (push_ok),
    .wr_data(push_entry),
    .pop    (pop),
    .head   (fifo_head),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Staging registers and entry assembly from the ADDR_HI write.
  always_comb begin
    stage_data_d = stage_data_q;
    stage_addr_d = stage_addr_q;
    push_req     = 1'b0;
    push_entry   = '0;
    push_entry[ALSB +: ADDR_W]            = {reg_wdata[ADDR_W-17:0], stage_addr_q};
    push_entry[ENTRY_DATA_LSB +: DATA_W]  = stage_data_q;
    push_entry[ENTRY_RW]                  = reg_wdata[HI_RW_BIT];
    push_entry[ENTRY_UDS]                 = reg_wdata[HI_BYTE_BIT] & stage_addr_q[0];
    push_entry[ENTRY_LDS]                 = reg_wdata[HI_BYTE_BIT] & ~stage_addr_q[0];
    if (reg_wr) begin
      case (reg_sel)
        REG_DATA:    stage_data_d = reg_wdata;
        REG_ADDR_LO: stage_addr_d = reg_wdata[15:0];
        REG_ADDR_HI: push_req     = 1'b1;
        default:     ;
      endcase
    end
  end

  always_comb begin
    state_d       = state_q;
    pop           = 1'b0;
    inflight_rd_d = inflight_rd_q;
    rd_data_d     = rd_data_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (op_ready) begin
          pop           = 1'b1;
          inflight_rd_d = fifo_head[ENTRY_RW];
          state_d       = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (op_done) begin
          if (inflight_rd_q) rd_data_d = op_rdata;
          // A push landing this cycle counts, so back-to-back posts see no idle bubble.
          state_d = (!fifo_empty || push_req) ? ST_ISSUE : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    push_ok    = push_req && (!fifo_full || pop);
    count_d    = fifo_count + CW'(push_ok) - CW'(pop);
    busy_d     = (count_d != '0) || (state_d != ST_IDLE);
    full_d     = (count_d == CW'(DEPTH));
    overflow_d = overflow_q;
    if (reg_wr && reg_sel == REG_STATUS) overflow_d = 1'b0;
    else if (push_req && fifo_full && !pop) overflow_d = 1'b1;
  end

  always_ff @(posedge PI_CLK or posedge PI_RST) begin
    if (PI_RST) begin
      state_q       <= ST_IDLE;
      stage_data_q  <= '0;
      stage_addr_q  <= '0;
      rd_data_q     <= '0;
      inflight_rd_q <= 1'b0;
      overflow_q    <= 1'b0;
      busy_q        <= 1'b0;
      full_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      stage_data_q  <= stage_data_d;
      stage_addr_q  <= stage_addr_d;
      rd_data_q     <= rd_data_d;
      inflight_rd_q <= inflight_rd_d;
      overflow_q    <= overflow_d;
      busy_q        <= busy_d;
      full_q        <= full_d;
    end
  end

  // Op fields are gated so they read as zero whenever nothing is offered.
  assign op_valid = (state_q == ST_ISSUE);
  assign op_addr  = op_valid ? fifo_head[ALSB +: ADDR_W] : '0;
  assign op_wdata = op_valid ? fifo_head[ENTRY_DATA_LSB +: DATA_W] : '0;
  assign op_rw    = op_valid & fifo_head[ENTRY_RW];
  assign op_uds_n = op_valid & fifo_head[ENTRY_UDS];
  assign op_lds_n = op_valid & fifo_head[ENTRY_LDS];

  assign rd_data  = rd_data_q;
  assign busy     = busy_q;
  assign full     = full_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_pistorm_txn_queue.sv
// Scoreboard bench for pistorm_txn_queue: modelled pushes are queued and
// compared against each op the DUT hands to the engine.
`timescale 1ns/1ps
module tb_pistorm_txn_queue;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              rw;
    logic              uds_n;
    logic              lds_n;
  } op_t;

  logic              PI_CLK = 1'b0;
  logic              PI_RST = 1'b1;
  logic              reg_wr = 1'b0;
  logic [1:0]        reg_sel = '0;
  logic [DATA_W-1:0] reg_wdata = '0;
  logic              op_valid;
  logic              op_ready = 1'b0;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_wdata;
  logic              op_rw;
  logic              op_uds_n;
  logic              op_lds_n;
  logic              op_done = 1'b0;
  logic [DATA_W-1:0] op_rdata = '0;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              full;
  logic              overflow;

  pistorm_txn_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .PI_CLK   (PI_CLK),
    .PI_RST   (PI_RST),
    .reg_wr   (reg_wr),
    .reg_sel  (reg_sel),
    .reg_wdata(reg_wdata),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op_addr  (op_addr),
    .op_wdata (op_wdata),
    .op_rw    (op_rw),
    .op_uds_n (op_uds_n),
    .op_lds_n (op_lds_n),
    .op_done  (op_done),
    .op_rdata (op_rdata),
    .rd_data  (rd_data),
    .busy     (busy),
    .full     (full),
    .overflow (overflow)
  );

  always #2.5 PI_CLK = ~PI_CLK;

  int  n_vec = 0;
  int  n_err = 0;
  op_t exp_q[$];
  logic [DATA_W-1:0] m_data = '0;
  logic [15:0]       m_addr = '0;
  logic              m_ovf  = 1'b0;

  // Issue monitor: compares each accepted op against the scoreboard and
  // checks that a stalled offer holds still.
  logic prev_v = 1'b0;
  logic prev_r = 1'b0;
  op_t  prev_op;
  op_t  cur_op;
  op_t  exp_op;

  always @(negedge PI_CLK) begin
    if (PI_RST) begin
      prev_v = 1'b0;
      prev_r = 1'b0;
    end else begin
      cur_op = '{addr: op_addr, wdata: op_wdata, rw: op_rw, uds_n: op_uds_n, lds_n: op_lds_n};
      if (prev_v && !prev_r && op_valid) begin
        n_vec++;
        if (cur_op !== prev_op) begin
          n_err++;
          $display("FAIL op_hold: got %h, required %h", cur_op, prev_op);
        end
      end
      if (op_valid && op_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL op_issue: got %h, required no op (scoreboard empty)", cur_op);
        end else begin
          exp_op = exp_q.pop_front();
          if (cur_op !== exp_op) begin
            n_err++;
            $display("FAIL op_issue: got %h, required %h", cur_op, exp_op);
          end
        end
      end
      prev_v  = op_valid;
      prev_r  = op_ready;
      prev_op = cur_op;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge PI_CLK);
    #1;
  endtask

  // Drives one register write for a cycle and updates the model; decides
  // drop vs push after the monitor has seen whether a pop shares the cycle.
  task automatic reg_write(input logic [1:0] sel, input logic [DATA_W-1:0] data);
    logic accept_now;
    op_t  e;
    reg_wr    = 1'b1;
    reg_sel   = sel;
    reg_wdata = data;
    @(negedge PI_CLK);
    #1;
    accept_now = op_valid && op_ready;
    case (sel)
      2'd0: m_data = data;
      2'd1: m_addr = data[15:0];
      2'd2: begin
        e.addr  = {data[7:0], m_addr};
        e.wdata = m_data;
        e.rw    = data[9];
        e.uds_n = data[8] ? m_addr[0] : 1'b0;
        e.lds_n = data[8] ? ~m_addr[0] : 1'b0;
        if (!accept_now && exp_q.size() == DEPTH) m_ovf = 1'b1;
        else exp_q.push_back(e);
      end
      default: m_ovf = 1'b0;
    endcase
    @(posedge PI_CLK);
    #1;
    reg_wr = 1'b0;
  endtask

  task automatic post_op(input logic [15:0] d, input logic [15:0] lo, input logic [15:0] hi);
    reg_write(2'd0, d);
    reg_write(2'd1, lo);
    reg_write(2'd2, hi);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!op_valid && n < 20) begin
      cyc(1);
      n++;
    end
    if (!op_valid) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: op_valid got 0 after 20 cycles, required 1", name);
    end
  endtask

  task automatic accept();
    op_ready = 1'b1;
    cyc(1);
    op_ready = 1'b0;
  endtask

  task automatic done(input logic [DATA_W-1:0] d);
    op_done  = 1'b1;
    op_rdata = d;
    cyc(1);
    op_done  = 1'b0;
    op_rdata = '0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_data = '0;
    m_addr = '0;
    m_ovf  = 1'b0;
  endtask

  task automatic test_reset();
    PI_RST = 1'b1;
    model_reset();
    cyc(2);
    n_vec++;
    if ({op_valid, busy, full, overflow, rd_data, op_addr, op_wdata, op_rw, op_uds_n, op_lds_n} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b b=%b f=%b o=%b rd=%h a=%h, required all 0",
               op_valid, busy, full, overflow, rd_data, op_addr);
    end
    PI_RST = 1'b0;
    cyc(2);
    n_vec++;
    if ({op_valid, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_release: got valid=%b busy=%b, required 0 0", op_valid, busy);
    end
  endtask

  task automatic test_ignored();
    op_ready = 1'b1;
    cyc(2);
    op_ready = 1'b0;
    done(16'hDEAD);
    n_vec++;
    if ({op_valid, busy, rd_data} !== {2'b00, 16'h0000}) begin
      n_err++;
      $display("FAIL idle_ignore: got valid=%b busy=%b rd=%h, required 0 0 0000", op_valid, busy, rd_data);
    end
  endtask

  task automatic test_word_write();
    post_op(16'hBEEF, 16'h1234, 16'h0000);
    n_vec++;
    if (op_valid !== 1'b0) begin
      n_err++;
      $display("FAIL latency_n1: op_valid got %b, required 0", op_valid);
    end
    cyc(1);
    n_vec++;
    if ({op_valid, busy} !== 2'b11) begin
      n_err++;
      $display("FAIL latency_n2: got valid=%b busy=%b, required 1 1", op_valid, busy);
    end
    accept();
    n_vec++;
    if ({op_valid, busy} !== 2'b01) begin
      n_err++;
      $display("FAIL wait_state: got valid=%b busy=%b, required 0 1", op_valid, busy);
    end
    done(16'h9999);
    n_vec++;
    if ({busy, rd_data} !== {1'b0, 16'h0000}) begin
      n_err++;
      $display("FAIL write_done: got busy=%b rd=%h, required 0 0000", busy, rd_data);
    end
  endtask

  task automatic test_byte_read();
    reg_write(2'd1, 16'h0001);
    reg_write(2'd2, 16'h0300);
    wait_valid("byte_read");
    n_vec++;
    if ({op_rw, op_uds_n, op_lds_n} !== 3'b110) begin
      n_err++;
      $display("FAIL byte_read_strobes: got rw/uds/lds=%b, required 110", {op_rw, op_uds_n, op_lds_n});
    end
    accept();
    done(16'h00A5);
    n_vec++;
    if ({busy, rd_data} !== {1'b0, 16'h00A5}) begin
      n_err++;
      $display("FAIL byte_read_data: got busy=%b rd=%h, required 0 00a5", busy, rd_data);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) begin
      post_op(16'h1000 + 16'(i), 16'h0200 + 16'(i), (i % 2 == 1) ? 16'h0140 : 16'h0041);
      if (i == 3) begin
        n_vec++;
        if ({full, overflow} !== 2'b10) begin
          n_err++;
          $display("FAIL fill_4: got full=%b ovf=%b, required 1 0", full, overflow);
        end
      end
    end
    n_vec++;
    if ({full, overflow} !== {1'b1, m_ovf}) begin
      n_err++;
      $display("FAIL fifth_drop: got full=%b ovf=%b, required 1 %b", full, overflow, m_ovf);
    end
    reg_write(2'd3, 16'h0000);
    n_vec++;
    if (overflow !== m_ovf) begin
      n_err++;
      $display("FAIL ovf_clear: got %b, required %b", overflow, m_ovf);
    end
    for (int i = 0; i < 4; i++) begin
      wait_valid("overflow_drain");
      accept();
      done(16'h0000);
    end
    n_vec++;
    if ({busy, full, 32'(exp_q.size())} !== {2'b00, 32'd0}) begin
      n_err++;
      $display("FAIL overflow_drain: got busy=%b full=%b left=%0d, required 0 0 0", busy, full, exp_q.size());
    end
  endtask

  task automatic test_push_accept_full();
    for (int i = 0; i < 4; i++)
      post_op(16'h2000 + 16'(i), 16'h0400 + 16'(i), 16'h0022);
    reg_write(2'd0, 16'h2FFF);
    reg_write(2'd1, 16'h0777);
    op_ready = 1'b1;
    reg_write(2'd2, 16'h0123);
    op_ready = 1'b0;
    n_vec++;
    if ({full, overflow, op_valid} !== {1'b1, m_ovf, 1'b0}) begin
      n_err++;
      $display("FAIL push_pop_full: got full=%b ovf=%b valid=%b, required 1 %b 0", full, overflow, op_valid, m_ovf);
    end
    done(16'h0000);
    for (int i = 0; i < 4; i++) begin
      wait_valid("push_pop_drain");
      accept();
      done(16'h0000);
    end
    n_vec++;
    if ({busy, 32'(exp_q.size())} !== {1'b0, 32'd0}) begin
      n_err++;
      $display("FAIL push_pop_drain: got busy=%b left=%0d, required 0 0", busy, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    post_op(16'h3000, 16'h0010, 16'h0205);
    post_op(16'h3001, 16'h0012, 16'h0005);
    post_op(16'h3002, 16'h0014, 16'h0005);
    wait_valid("reset_mid");
    accept();
    PI_RST = 1'b1;
    #1;
    n_vec++;
    if ({op_valid, busy, full} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_mid: got valid=%b busy=%b full=%b, required 0 0 0", op_valid, busy, full);
    end
    model_reset();
    cyc(1);
    PI_RST = 1'b0;
    cyc(1);
    done(16'h5A5A);
    cyc(3);
    n_vec++;
    if ({op_valid, busy, rd_data} !== {2'b00, 16'h0000}) begin
      n_err++;
      $display("FAIL late_done: got valid=%b busy=%b rd=%h, required 0 0 0000", op_valid, busy, rd_data);
    end
  endtask

  task automatic test_write_then_read();
    post_op(16'h1111, 16'h0100, 16'h0012);
    post_op(16'h2222, 16'h0203, 16'h0312);
    wait_valid("order_first");
    n_vec++;
    if (op_rw !== 1'b0) begin
      n_err++;
      $display("FAIL order_first: op_rw got %b, required 0", op_rw);
    end
    accept();
    done(16'h7777);
    n_vec++;
    if (rd_data !== 16'h0000) begin
      n_err++;
      $display("FAIL write_no_rd: rd_data got %h, required 0000", rd_data);
    end
    wait_valid("order_second");
    n_vec++;
    if (op_rw !== 1'b1) begin
      n_err++;
      $display("FAIL order_second: op_rw got %b, required 1", op_rw);
    end
    accept();
    done(16'h3C3C);
    n_vec++;
    if ({rd_data, busy} !== {16'h3C3C, 1'b0}) begin
      n_err++;
      $display("FAIL read_rd: got rd=%h busy=%b, required 3c3c 0", rd_data, busy);
    end
  endtask

  initial begin
    test_reset();
    test_ignored();
    test_word_write();
    test_byte_read();
    test_overflow();
    test_push_accept_full();
    test_reset_mid();
    test_write_then_read();
    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
